// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int IMEM_AW = 7;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's memory, core-control and decode-side signals.
interface fetch_if import fetch_pkg::*; ();

    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_instr;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_instr;
    logic [31:0]        out_pc;
    logic               misaligned;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, misaligned,
        input  imem_instr, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, misaligned,
        output imem_instr, redirect_valid, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over a same-cycle push.
module fetch_queue import fetch_pkg::*; #(
    parameter int  QDEPTH = 2,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;
    fetch_entry_t  mem [QDEPTH];

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the PC, sequences instruction memory
// and feeds decode through a small prefetch queue.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   pc;
    logic          misaligned_q;
    logic          pop;
    logic          push;
    logic          space;
    fetch_entry_t  q_head;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    assign pop   = ~q_empty & bus.out_ready;
    assign space = (int'(q_count) < QDEPTH) | (q_full & pop);
    assign push  = (state == FETCH) & ~bus.halt & ~bus.redirect_valid & space;

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry ('{pc: pc, instr: bus.imem_instr}),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    // A redirect overrides every state; a misaligned target leaves pc untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            misaligned_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            if (is_aligned(bus.redirect_pc)) begin
                pc           <= bus.redirect_pc;
                state        <= bus.halt ? HALTED : FETCH;
                misaligned_q <= 1'b0;
            end else begin
                state        <= ERROR;
                misaligned_q <= 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (bus.halt)  state <= HALTED;
                    else if (push) pc    <= pc + 32'd4;
                end
                HALTED: begin
                    if (!bus.halt) state <= FETCH;
                end
                ERROR: state <= ERROR;
                default: begin
                    state        <= FETCH;
                    misaligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr  = pc[IMEM_AW+1:2];
    assign bus.out_valid  = ~q_empty;
    assign bus.out_instr  = q_empty ? 32'h0 : q_head.instr;
    assign bus.out_pc     = q_empty ? 32'h0 : q_head.pc;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, async-reset sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int QD = 2;
    localparam int M_RUN = 0, M_HOLD = 1, M_ERR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus ();
    logic [31:0] imem [128];
    assign bus.imem_instr = imem[bus.imem_addr];

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        halt;
        logic        ready;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic        em;
        logic [6:0]  ea;
    } vec_t;
    vec_t vq[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ment_t;
    ment_t       mq[$];
    logic [31:0] mpc;
    int          mmode;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ei, input logic em, input logic [6:0] ea);
        chk({tag, " out_valid"},  {31'b0, bus.out_valid},  {31'b0, ev});
        chk({tag, " out_pc"},     bus.out_pc,              epc);
        chk({tag, " out_instr"},  bus.out_instr,           ei);
        chk({tag, " misaligned"}, {31'b0, bus.misaligned}, {31'b0, em});
        chk({tag, " imem_addr"},  {25'b0, bus.imem_addr},  {25'b0, ea});
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                       input logic em, input logic [6:0] ea);
        vec_t v;
        v = '{rv, rpc, h, rdy, ev, epc, ei, em, ea};
        vq.push_back(v);
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.out_ready      = rdy;
    endtask

    // Reference model: one call per clock edge with the inputs sampled there.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        logic  pop;
        ment_t e;
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            if (rpc[1:0] == 2'b00) begin
                mpc   = rpc;
                mmode = h ? M_HOLD : M_RUN;
            end else begin
                mmode = M_ERR;
            end
        end else if (mmode == M_RUN) begin
            if (h) mmode = M_HOLD;
            else if (mq.size() < QD) begin
                e.pc    = mpc;
                e.instr = imem[mpc[8:2]];
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end else if (mmode == M_HOLD) begin
            if (!h) mmode = M_RUN;
        end
    endtask

    task automatic model_check(input string tag);
        logic ev;
        ev = mq.size() > 0;
        chk_all(tag, ev, ev ? mq[0].pc : 32'h0, ev ? mq[0].instr : 32'h0,
                mmode == M_ERR, mpc[8:2]);
    endtask

    initial begin
        logic        rv, h, rdy;
        logic [31:0] rpc;

        for (int k = 0; k < 128; k++) imem[k] = 32'hA000_0000 + k;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1 chk_all("reset", 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
        @(negedge clk) rst_n = 1'b1;

        //  rv  rpc          halt rdy  valid pc           instr          mis addr
        add(0, 32'h0,        0,   1,   1,    32'h0,       32'hA000_0000, 0,  7'd1);
        add(0, 32'h0,        0,   1,   1,    32'h4,       32'hA000_0001, 0,  7'd2);
        add(0, 32'h0,        0,   0,   1,    32'h4,       32'hA000_0001, 0,  7'd3);
        add(0, 32'h0,        0,   0,   1,    32'h4,       32'hA000_0001, 0,  7'd3);
        add(0, 32'h0,        0,   0,   1,    32'h4,       32'hA000_0001, 0,  7'd3);
        add(0, 32'h0,        0,   1,   1,    32'h8,       32'hA000_0002, 0,  7'd4);
        add(1, 32'h40,       0,   0,   0,    32'h0,       32'h0,         0,  7'd16);
        add(0, 32'h0,        0,   0,   1,    32'h40,      32'hA000_0010, 0,  7'd17);
        add(0, 32'h0,        0,   0,   1,    32'h40,      32'hA000_0010, 0,  7'd18);
        add(1, 32'h40,       0,   1,   0,    32'h0,       32'h0,         0,  7'd16);
        add(1, 32'h1FC,      0,   1,   0,    32'h0,       32'h0,         0,  7'd127);
        add(0, 32'h0,        0,   0,   1,    32'h1FC,     32'hA000_007F, 0,  7'd0);
        add(0, 32'h0,        0,   1,   1,    32'h200,     32'hA000_0000, 0,  7'd1);
        add(1, 32'h42,       0,   0,   0,    32'h0,       32'h0,         1,  7'd1);
        add(0, 32'h0,        1,   1,   0,    32'h0,       32'h0,         1,  7'd1);
        add(0, 32'h0,        0,   1,   0,    32'h0,       32'h0,         1,  7'd1);
        add(1, 32'h80,       0,   1,   0,    32'h0,       32'h0,         0,  7'd32);
        add(0, 32'h0,        0,   0,   1,    32'h80,      32'hA000_0020, 0,  7'd33);
        add(0, 32'h0,        1,   0,   1,    32'h80,      32'hA000_0020, 0,  7'd33);
        add(0, 32'h0,        1,   1,   0,    32'h0,       32'h0,         0,  7'd33);
        add(0, 32'h0,        1,   1,   0,    32'h0,       32'h0,         0,  7'd33);
        add(1, 32'h100,      1,   1,   0,    32'h0,       32'h0,         0,  7'd64);
        add(0, 32'h0,        1,   1,   0,    32'h0,       32'h0,         0,  7'd64);
        add(0, 32'h0,        0,   1,   0,    32'h0,       32'h0,         0,  7'd64);
        add(0, 32'h0,        0,   1,   1,    32'h100,     32'hA000_0040, 0,  7'd65);
        add(0, 32'h0,        0,   1,   1,    32'h104,     32'hA000_0041, 0,  7'd66);

        foreach (vq[i]) begin
            drive(vq[i].rv, vq[i].rpc, vq[i].halt, vq[i].ready);
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].ei, vq[i].em, vq[i].ea);
        end

        // Asynchronous reset while in the error state.
        drive(1'b1, 32'h42, 1'b0, 1'b0);
        @(posedge clk);
        #1 chk("err entry misaligned", {31'b0, bus.misaligned}, 32'h1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("async rst err", 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset with a full queue.
        repeat (2) @(posedge clk);
        #1 chk_all("prefill", 1'b1, 32'h0, 32'hA000_0000, 1'b0, 7'd2);
        #2 rst_n = 1'b0;
        #1 chk_all("async rst full", 1'b0, 32'h0, 32'h0, 1'b0, 7'd0);
        @(negedge clk) rst_n = 1'b1;

        mq.delete();
        mpc   = 32'h0;
        mmode = M_RUN;
        h     = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) h = ~h;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            drive(rv, rpc, h, rdy);
            @(posedge clk);
            model_step(rv, rpc, h, rdy);
            #1 model_check($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch controller that sequences the 128-word instruction memory. It owns the program counter and drives the memory's 7-bit word address. Each returned 32-bit instruction is captured with its PC into a small prefetch queue, which feeds decode over a valid/ready handshake. It sits between the instruction memory (instantiated by the parent) and the decode stage, and accepts redirects (branch/jump targets) and a halt request from the core.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned
- QDEPTH, 2, prefetch queue entries; power of two, 2..8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  7  word address to instruction memory, = pc[8:2]
- imem_instr  in  32  combinational read data for imem_addr
- redirect_valid  in  1  load redirect_pc this cycle
- redirect_pc  in  32  new byte PC
- halt  in  1  level; suppresses new fetches while high
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- misaligned  out  1  high while in ERROR state

## Operation
- State machine (fetch_state_t): FETCH, HALTED, ERROR. Reset state: FETCH; pc = RESET_PC; queue empty.
- FETCH: push {pc, imem_instr} when space, then pc += 4. Space = count < QDEPTH, or count == QDEPTH with pop this cycle.
- FETCH -> HALTED when halt=1 (no push that cycle); HALTED -> FETCH when halt=0. The queue keeps draining in HALTED.
- Pop = out_valid & out_ready. The queue is FIFO; out_* show the head; out_instr and out_pc are 0 when empty.
- Redirect (any state), if redirect_pc[1:0]==0:
  - flush the queue and load pc = redirect_pc; no push that cycle;
  - next state is HALTED if halt=1, else FETCH.
- Redirect with redirect_pc[1:0]!=0: flush, pc unchanged, go to ERROR.
- ERROR: no fetches; misaligned=1. Only an aligned redirect leaves ERROR (follows the redirect rule above). Halt is ignored in ERROR.
- Arithmetic: pc is 32-bit and wraps modulo 2^32. imem_addr = pc[8:2], so it wraps 127 -> 0 every 512 bytes; no error is raised for this.
- Simultaneous events:
  - redirect + pop: the pop completes (decode owns that entry) and the flush clears the rest;
  - redirect + halt: the redirect loads pc, then HALTED;
  - push + pop on a full queue: both happen, count unchanged.

## Timing
- Reset values: out_valid=0, out_instr=0, out_pc=0, misaligned=0, imem_addr=RESET_PC[8:2].
- imem_addr is combinational from the pc register. Push at edge N gives out_valid=1 after edge N (1-cycle fetch latency).
- After reset release: first push at the first edge; out_valid high from the 2nd cycle.
- With out_ready held at 1: sustained 1 instruction/cycle.
- Redirect sampled at edge N: out_valid=0 after N; target fetched at N+1; target visible after N+1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Structure
- fetch_pkg holds:
  - fetch_state_t enum;
  - the queue entry struct fetch_entry_t {pc[31:0], instr[31:0]};
  - the word-address-width constant IMEM_AW = 7.
- Sub-module fetch_queue: a synchronous FIFO with push, pop and flush (flush has priority over push), plus count and full/empty. It is parameterised by QDEPTH.
- The top level holds pc, the FSM, and the push/space logic.

## Test plan
- Reset with RESET_PC=0, memory word k = 32'hA000_0000+k, out_ready=1 -> from cycle 2, one entry per cycle: (pc 0, A0000000), (4, A0000001), ...
- out_ready=0 for 5 cycles -> exactly QDEPTH pushes, then pc holds and imem_addr is stable. Then out_ready=1 -> entries resume in order, none lost or duplicated.
- Redirect to 32'h40 while the queue holds 2 entries -> out_valid=0 next cycle, then (pc 0x40, word 16). Repeat the same redirect with pop asserted -> the head is popped once, the rest is flushed.
- Redirect to 32'h1FC, run 2 fetches -> imem_addr 127 then 0; out_pc 0x1FC then 0x200.
- Redirect to 32'h42 -> misaligned=1, queue empty, no further pushes. Then redirect to 32'h80 -> misaligned=0, fetch resumes at 0x80.
- halt=1 for 4 cycles with out_ready=1 -> the queue drains to empty and pc is frozen. Redirect + halt together -> pc loaded, still no pushes. halt=0 -> fetch resumes at the redirect target.
